qnet_cmd_arb: RTL and testbench
===============================

// Module: qnet_cmd_arb
// PURPOSE
//  Arbitrates QICK control commands from N_SRC requesters (network RX, local core, AXI regs) onto the single
//  ctrl_cmd_req/op/dt/rdy port of qnet_qick_cmd. One slot buffers each requester; grants are round-robin with
//  optional fixed priority for source 0. Tracks each command through accept and completion, then reports
//  done or drop to the owning requester. Sits in the t_clk_i domain between the requesters and qnet_qick_cmd.
// PARAMETERS
//  N_SRC     3   number of requesters (2..8)
//  DT_W      48  command time width
//  CNT_W     16  drop/error counter width (saturating)
//  PRIO0     1   1: source 0 always wins when pending; 0: pure round-robin
// PORTS
//  t_clk_i          in   1            clock
//  t_rst_ni         in   1            reset, asynchronous, active-low
//  src_req_i        in   N_SRC x TYPE_CTRL_REQ  per-source request; non-X_NOP for 1 cycle = new command
//  src_op_i         in   N_SRC x TYPE_CTRL_OP   operation, valid with src_req_i
//  src_dt_i         in   N_SRC x DT_W           execution time, valid with src_req_i
//  src_busy_o       out  N_SRC        slot occupied (pending or in flight)
//  src_done_o       out  N_SRC        1-cycle pulse: command completed downstream
//  src_drop_o       out  N_SRC        1-cycle pulse: request arrived while slot busy, discarded
//  ctrl_cmd_req_o   out  TYPE_CTRL_REQ  to qnet_qick_cmd
//  ctrl_cmd_op_o    out  TYPE_CTRL_OP   to qnet_qick_cmd
//  ctrl_cmd_dt_o    out  DT_W           to qnet_qick_cmd
//  ctrl_cmd_rdy_i   in   1            qnet_qick_cmd idle/ready
//  arb_gnt_o        out  $clog2(N_SRC)  source currently granted
//  arb_st_o         out  3            FSM state, debug
//  drop_cnt_o       out  CNT_W        total drops, saturating
//  err_cnt_o        out  CNT_W        protocol errors (no accept seen), saturating
// BEHAVIOUR
//  Reset (async): all slots empty; ctrl_cmd_req_o=X_NOP, op=NOP, dt=0; all pulses 0; gnt=0; counters 0; FSM A_IDLE.
//  Slot capture: on src_req_i[i]!=X_NOP, if slot i is empty, or is being cleared this cycle (done), latch req/op/dt
//   and set busy next cycle. Otherwise assert src_drop_o[i] next cycle and increment drop_cnt (several drops in
//   one cycle add their count). Slot contents stay stable until done.
//  Pick: among pending, not-in-flight slots. PRIO0=1 and slot 0 pending -> 0; else the first pending slot after
//   the last grant (round-robin, wraps N_SRC-1 -> 0). Pointer advances only on a successful issue.
//  FSM (registered outputs):
//   A_IDLE:      a slot pending and ctrl_cmd_rdy_i=1 -> load outputs from picked slot, set gnt -> A_ISSUE.
//   A_ISSUE:     ctrl_cmd_req_o is non-NOP for exactly this cycle; outputs return to X_NOP next cycle -> A_WAIT_ACC.
//   A_WAIT_ACC:  rdy_i=0 -> A_WAIT_DONE. rdy_i=1 -> protocol error: err_cnt++, slot stays pending, no pointer
//                advance -> A_IDLE (retry).
//   A_WAIT_DONE: hold until rdy_i=1, then pulse src_done_o[gnt], clear slot -> A_IDLE. No timeout: X_TIME and X_EXT
//                may wait indefinitely. A downstream T_ERROR also returns rdy and is reported as done.
//  Latency: src_req_i pulse in cycle 0 -> ctrl_cmd_req_o in cycle 2 (idle arbiter, rdy_i high).
//   X_NOW: rdy low cycles 3..4, done pulse in cycle 5.
//  Back-to-back: the next issue is no earlier than 1 cycle after a done (IDLE re-evaluates).
//  ctrl_cmd_req_o is never non-NOP while rdy_i=0 in the load cycle. op/dt are held stable from ISSUE until the
//   next load.
//  A mid-operation reset abandons the in-flight command; no done pulse is generated.
// STRUCTURE
//  Shared package (_qnet_defines): TYPE_CTRL_REQ, TYPE_CTRL_OP (existing), new TYPE_ARB_ST enum
//   {A_IDLE, A_ISSUE, A_WAIT_ACC, A_WAIT_DONE}.
//  Sub-module qnet_rr_pick: pending mask + last-grant pointer + PRIO0 -> grant index and valid (combinational).
//  Slot array, FSM and counters stay in this module.
// TESTING
//  1 Single X_NOW QICK_CORE_START on src1, dt=0; model rdy per qnet_qick_cmd -> req_o in cycle 2, done[1] in cycle 5,
//    busy[1] high cycles 1..5.
//  2 src0,1,2 all request in cycle 0, PRIO0=0 -> grants in order 0,1,2; PRIO0=1 with src0 re-requesting after each
//    done -> src0 wins each time until it stops, then 1,2.
//  3 src2 requests twice while busy (X_TIME, dt=1000) -> one drop_o[2] pulse, drop_cnt=1, first command completes.
//  4 Request on src1 in the same cycle as done[1] -> accepted, no drop, reissued after the next IDLE.
//  5 rdy_i held high after ISSUE -> err_cnt=1, same command reissued, done once rdy toggles.
//  6 Reset asserted during A_WAIT_DONE -> outputs NOP immediately, busy=0, no done; fresh request after release works.

Source files
------------

// File: rtl/qnet_cmd_arb_pkg.sv
// rtl/qnet_cmd_arb_pkg.sv - shared QICK control command types and arbiter state encoding
package qnet_cmd_arb_pkg;

    typedef enum logic [1:0] {
        X_NOP  = 2'd0,
        X_NOW  = 2'd1,
        X_TIME = 2'd2,
        X_EXT  = 2'd3
    } TYPE_CTRL_REQ;

    typedef enum logic [3:0] {
        NOP             = 4'd0,
        QICK_TIME_RST   = 4'd1,
        QICK_TIME_UPDT  = 4'd2,
        QICK_CORE_START = 4'd3,
        QICK_CORE_STOP  = 4'd4
    } TYPE_CTRL_OP;

    typedef enum logic [2:0] {
        A_IDLE      = 3'd0,
        A_ISSUE     = 3'd1,
        A_WAIT_ACC  = 3'd2,
        A_WAIT_DONE = 3'd3
    } TYPE_ARB_ST;

    localparam int MAX_SRC = 8;

    function automatic logic [3:0] popcnt8(input logic [MAX_SRC-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_SRC; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/qnet_rr_pick.sv
// rtl/qnet_rr_pick.sv - round-robin pick over a pending mask, optional fixed priority for source 0
module qnet_rr_pick #(
    parameter int N_SRC = 3,
    parameter bit PRIO0 = 1'b1
) (
    input  logic [N_SRC-1:0]         pend_i,
    input  logic [$clog2(N_SRC)-1:0] last_i,
    output logic [$clog2(N_SRC)-1:0] gnt_o,
    output logic                     vld_o
);
    localparam int GW = $clog2(N_SRC);

    always_comb begin
        int idx;
        gnt_o = '0;
        vld_o = 1'b0;
        idx   = 0;
        if (PRIO0 && pend_i[0]) begin
            vld_o = 1'b1;
        end else begin
            // Scan starts one past the last grant so the last winner is considered last.
            for (int k = 1; k <= N_SRC; k++) begin
                idx = (int'(last_i) + k) % N_SRC;
                if (!vld_o && pend_i[idx]) begin
                    vld_o = 1'b1;
                    gnt_o = GW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/qnet_cmd_arb.sv
// rtl/qnet_cmd_arb.sv - arbitrates per-source QICK control commands onto the single qnet_qick_cmd port
module qnet_cmd_arb
    import qnet_cmd_arb_pkg::*;
#(
    parameter int N_SRC = 3,
    parameter int DT_W  = 48,
    parameter int CNT_W = 16,
    parameter bit PRIO0 = 1'b1
) (
    input  logic                     t_clk_i,
    input  logic                     t_rst_ni,
    input  TYPE_CTRL_REQ             src_req_i [N_SRC],
    input  TYPE_CTRL_OP              src_op_i  [N_SRC],
    input  logic [DT_W-1:0]          src_dt_i  [N_SRC],
    output logic [N_SRC-1:0]         src_busy_o,
    output logic [N_SRC-1:0]         src_done_o,
    output logic [N_SRC-1:0]         src_drop_o,
    output TYPE_CTRL_REQ             ctrl_cmd_req_o,
    output TYPE_CTRL_OP              ctrl_cmd_op_o,
    output logic [DT_W-1:0]          ctrl_cmd_dt_o,
    input  logic                     ctrl_cmd_rdy_i,
    output logic [$clog2(N_SRC)-1:0] arb_gnt_o,
    output logic [2:0]               arb_st_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic [CNT_W-1:0]         err_cnt_o
);
    localparam int GW = $clog2(N_SRC);

    TYPE_CTRL_REQ     slot_req [N_SRC];
    TYPE_CTRL_OP      slot_op  [N_SRC];
    logic [DT_W-1:0]  slot_dt  [N_SRC];
    logic [N_SRC-1:0] busy;
    logic [N_SRC-1:0] drop_q;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] err_cnt;

    TYPE_ARB_ST       state;
    logic [GW-1:0]    gnt_q;
    logic [GW-1:0]    last_q;
    TYPE_CTRL_REQ     req_q;
    TYPE_CTRL_OP      op_q;
    logic [DT_W-1:0]  dt_q;

    logic [N_SRC-1:0] gnt_oh;
    logic [N_SRC-1:0] done_vec;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] accept;
    logic [N_SRC-1:0] drop_v;
    logic [CNT_W:0]   drop_sum;
    logic [GW-1:0]    pick;
    logic             pick_vld;

    assign gnt_oh = {{(N_SRC-1){1'b0}}, 1'b1} << gnt_q;

    always_comb begin
        done_vec = '0;
        pend     = busy;
        if (state == A_WAIT_DONE && ctrl_cmd_rdy_i) begin
            done_vec = gnt_oh;
        end
        if (state != A_IDLE) begin
            pend = busy & ~gnt_oh;
        end
    end

    // A slot freed by this cycle's done pulse can take a new command in the same cycle.
    always_comb begin
        accept = '0;
        drop_v = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_req_i[i] != X_NOP) begin
                if (!busy[i] || done_vec[i]) begin
                    accept[i] = 1'b1;
                end else begin
                    drop_v[i] = 1'b1;
                end
            end
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(popcnt8(MAX_SRC'(drop_v)));

    qnet_rr_pick #(
        .N_SRC (N_SRC),
        .PRIO0 (PRIO0)
    ) u_pick (
        .pend_i (pend),
        .last_i (last_q),
        .gnt_o  (pick),
        .vld_o  (pick_vld)
    );

    always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
        if (!t_rst_ni) begin
            busy     <= '0;
            drop_q   <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                slot_req[i] <= X_NOP;
                slot_op[i]  <= NOP;
                slot_dt[i]  <= '0;
            end
        end else begin
            drop_q   <= drop_v;
            drop_cnt <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
            for (int i = 0; i < N_SRC; i++) begin
                if (accept[i]) begin
                    slot_req[i] <= src_req_i[i];
                    slot_op[i]  <= src_op_i[i];
                    slot_dt[i]  <= src_dt_i[i];
                    busy[i]     <= 1'b1;
                end else if (done_vec[i]) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
        if (!t_rst_ni) begin
            state   <= A_IDLE;
            gnt_q   <= '0;
            last_q  <= '0;
            req_q   <= X_NOP;
            op_q    <= NOP;
            dt_q    <= '0;
            err_cnt <= '0;
        end else begin
            case (state)
                A_IDLE: begin
                    if (pick_vld && ctrl_cmd_rdy_i) begin
                        req_q <= slot_req[pick];
                        op_q  <= slot_op[pick];
                        dt_q  <= slot_dt[pick];
                        gnt_q <= pick;
                        state <= A_ISSUE;
                    end
                end
                A_ISSUE: begin
                    req_q <= X_NOP;
                    state <= A_WAIT_ACC;
                end
                A_WAIT_ACC: begin
                    // Downstream never dropped rdy, so the command was not taken; retry from IDLE.
                    if (!ctrl_cmd_rdy_i) begin
                        last_q <= gnt_q;
                        state  <= A_WAIT_DONE;
                    end else begin
                        if (err_cnt != {CNT_W{1'b1}}) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        state <= A_IDLE;
                    end
                end
                A_WAIT_DONE: begin
                    if (ctrl_cmd_rdy_i) begin
                        state <= A_IDLE;
                    end
                end
                default: state <= A_IDLE;
            endcase
        end
    end

    assign src_busy_o     = busy;
    assign src_done_o     = done_vec;
    assign src_drop_o     = drop_q;
    assign ctrl_cmd_req_o = req_q;
    assign ctrl_cmd_op_o  = op_q;
    assign ctrl_cmd_dt_o  = dt_q;
    assign arb_gnt_o      = gnt_q;
    assign arb_st_o       = state;
    assign drop_cnt_o     = drop_cnt;
    assign err_cnt_o      = err_cnt;

endmodule

// File: tb/tb_qnet_cmd_arb.sv
// tb/tb_qnet_cmd_arb.sv - scoreboard bench for qnet_cmd_arb with a qnet_qick_cmd rdy model
module tb_qnet_cmd_arb;
    import qnet_cmd_arb_pkg::*;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    TYPE_CTRL_REQ src_req [N];
    TYPE_CTRL_OP  src_op  [N];
    logic [47:0]  src_dt  [N];
    logic [N-1:0] busy, done, drop;
    TYPE_CTRL_REQ ctrl_req;
    TYPE_CTRL_OP  ctrl_op;
    logic [47:0]  ctrl_dt;
    logic         rdy;
    logic [1:0]   gnt;
    logic [2:0]   st;
    logic [15:0]  drop_cnt, err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int seen_drop = 0;
    int ign_req = 0;
    int ign_used = 0;
    int mcnt;

    typedef struct {
        int          src;
        TYPE_CTRL_OP op;
        logic [47:0] dt;
    } exp_t;
    exp_t iq[$];
    int   dq[$];

    qnet_cmd_arb #(.N_SRC(N), .DT_W(48), .CNT_W(16), .PRIO0(1'b1)) dut (
        .t_clk_i        (clk),
        .t_rst_ni       (rst_n),
        .src_req_i      (src_req),
        .src_op_i       (src_op),
        .src_dt_i       (src_dt),
        .src_busy_o     (busy),
        .src_done_o     (done),
        .src_drop_o     (drop),
        .ctrl_cmd_req_o (ctrl_req),
        .ctrl_cmd_op_o  (ctrl_op),
        .ctrl_cmd_dt_o  (ctrl_dt),
        .ctrl_cmd_rdy_i (rdy),
        .arb_gnt_o      (gnt),
        .arb_st_o       (st),
        .drop_cnt_o     (drop_cnt),
        .err_cnt_o      (err_cnt)
    );

    always #5 clk = ~clk;

    // qnet_qick_cmd model: rdy falls the cycle after a taken command, stays low 2/8/4 cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy  <= 1'b1;
            mcnt <= 0;
        end else if (!rdy) begin
            if (mcnt == 0) rdy <= 1'b1;
            else mcnt <= mcnt - 1;
        end else if (ctrl_req != X_NOP) begin
            if (ign_used != ign_req) begin
                ign_used <= ign_used + 1;
            end else begin
                rdy  <= 1'b0;
                mcnt <= (ctrl_req == X_NOW) ? 1 : (ctrl_req == X_TIME) ? 7 : 3;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ctrl_req != X_NOP) begin
                chk("issue_rdy", 64'(rdy), 64'd1);
                if (iq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL issue_unexpected: got src %0d expected none", gnt);
                end else begin
                    exp_t e;
                    e = iq.pop_front();
                    chk("issue_src", 64'(gnt), 64'(e.src));
                    chk("issue_op", 64'(ctrl_op), 64'(e.op));
                    chk("issue_dt", 64'(ctrl_dt), 64'(e.dt));
                end
            end
            if (done != '0) begin
                if (dq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL done_unexpected: got %b expected none", done);
                end else begin
                    int s;
                    s = dq.pop_front();
                    chk("done_src", 64'(done), 64'(1 << s));
                end
            end
            for (int i = 0; i < N; i++) if (drop[i]) seen_drop++;
        end
    end

    task automatic set_req(input int i, input TYPE_CTRL_REQ r, input TYPE_CTRL_OP o, input logic [47:0] d);
        src_req[i] = r;
        src_op[i]  = o;
        src_dt[i]  = d;
    endtask

    task automatic step_clear();
        @(negedge clk);
        for (int i = 0; i < N; i++) src_req[i] = X_NOP;
    endtask

    task automatic send(input int i, input TYPE_CTRL_REQ r, input TYPE_CTRL_OP o, input logic [47:0] d);
        set_req(i, r, o, d);
        step_clear();
    endtask

    task automatic push_iss(input int s, input TYPE_CTRL_OP o, input logic [47:0] d);
        exp_t e;
        e.src = s;
        e.op  = o;
        e.dt  = d;
        iq.push_back(e);
    endtask

    task automatic wait_done(input int s);
        int k;
        k = 0;
        while (!done[s] && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("wait_done", 64'(done[s]), 64'd1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(busy == '0 && st == 3'(A_IDLE)) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("wait_idle", 64'(busy == '0 && st == 3'(A_IDLE)), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_req(i, X_NOP, NOP, 48'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_req", 64'(ctrl_req), 64'(X_NOP));
        chk("rst_op", 64'(ctrl_op), 64'(NOP));
        chk("rst_dt", 64'(ctrl_dt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_st", 64'(st), 64'(A_IDLE));
        chk("rst_cnt", 64'({drop_cnt, err_cnt}), 64'd0);

        // 1: single X_NOW on src1, cycle-exact latency
        push_iss(1, QICK_CORE_START, 48'd0);
        dq.push_back(1);
        send(1, X_NOW, QICK_CORE_START, 48'd0);
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("t1_busy_c%0d", c), 64'(busy[1]), 64'(c <= 5));
            chk($sformatf("t1_req_c%0d", c), 64'(ctrl_req), 64'((c == 2) ? X_NOW : X_NOP));
            chk($sformatf("t1_done_c%0d", c), 64'(done[1]), 64'(c == 5));
            @(negedge clk);
        end
        wait_idle();

        // 2: all three at once, src0 re-requests on its done twice -> 0,0,0,1,2
        push_iss(0, QICK_TIME_RST, 48'd100);
        push_iss(0, QICK_TIME_RST, 48'd200);
        push_iss(0, QICK_TIME_RST, 48'd201);
        push_iss(1, QICK_CORE_START, 48'd101);
        push_iss(2, QICK_CORE_STOP, 48'd102);
        dq.push_back(0); dq.push_back(0); dq.push_back(0); dq.push_back(1); dq.push_back(2);
        set_req(0, X_NOW, QICK_TIME_RST, 48'd100);
        set_req(1, X_NOW, QICK_CORE_START, 48'd101);
        set_req(2, X_NOW, QICK_CORE_STOP, 48'd102);
        step_clear();
        for (int k = 0; k < 2; k++) begin
            wait_done(0);
            send(0, X_NOW, QICK_TIME_RST, 48'(200 + k));
        end
        wait_idle();

        // round-robin: last grant 1, then src1 and src2 together -> 2 before 1
        push_iss(1, QICK_CORE_STOP, 48'd5);
        dq.push_back(1);
        send(1, X_NOW, QICK_CORE_STOP, 48'd5);
        wait_idle();
        push_iss(2, QICK_TIME_UPDT, 48'd22);
        push_iss(1, QICK_CORE_START, 48'd21);
        dq.push_back(2); dq.push_back(1);
        set_req(1, X_NOW, QICK_CORE_START, 48'd21);
        set_req(2, X_EXT, QICK_TIME_UPDT, 48'd22);
        step_clear();
        wait_idle();

        // 3: second request on busy src2 is dropped
        push_iss(2, QICK_TIME_UPDT, 48'd1000);
        dq.push_back(2);
        send(2, X_TIME, QICK_TIME_UPDT, 48'd1000);
        send(2, X_TIME, QICK_TIME_UPDT, 48'd1001);
        chk("t3_drop_pulse", 64'(drop), 64'b100);
        chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);
        @(negedge clk);
        chk("t3_drop_clear", 64'(drop), 64'd0);
        wait_idle();

        // 4: request on src1 in the cycle of done[1]
        push_iss(1, QICK_CORE_START, 48'd11);
        push_iss(1, QICK_CORE_STOP, 48'd12);
        dq.push_back(1); dq.push_back(1);
        send(1, X_NOW, QICK_CORE_START, 48'd11);
        wait_done(1);
        send(1, X_NOW, QICK_CORE_STOP, 48'd12);
        chk("t4_no_drop", 64'(drop), 64'd0);
        chk("t4_busy", 64'(busy[1]), 64'd1);
        chk("t4_req_idle", 64'(ctrl_req), 64'(X_NOP));
        @(negedge clk);
        chk("t4_reissue", 64'(ctrl_req), 64'(X_NOW));
        wait_idle();

        // 5: downstream ignores the first issue -> error, reissue
        ign_req = ign_req + 1;
        push_iss(0, QICK_TIME_RST, 48'd33);
        push_iss(0, QICK_TIME_RST, 48'd33);
        dq.push_back(0);
        send(0, X_NOW, QICK_TIME_RST, 48'd33);
        wait_idle();
        chk("t5_err_cnt", 64'(err_cnt), 64'd1);
        chk("t5_drop_cnt", 64'(drop_cnt), 64'd1);

        // 6: reset during A_WAIT_DONE
        push_iss(1, QICK_CORE_START, 48'd77);
        send(1, X_TIME, QICK_CORE_START, 48'd77);
        begin
            int k;
            k = 0;
            while (st != 3'(A_WAIT_DONE) && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("t6_reach_wait", 64'(st), 64'(A_WAIT_DONE));
        end
        rst_n = 1'b0;
        #1;
        chk("t6_req", 64'(ctrl_req), 64'(X_NOP));
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_st", 64'(st), 64'(A_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_iss(1, QICK_CORE_STOP, 48'd78);
        dq.push_back(1);
        send(1, X_NOW, QICK_CORE_STOP, 48'd78);
        wait_idle();
        chk("t6_cnt_cleared", 64'({drop_cnt, err_cnt}), 64'd0);

        repeat (3) @(negedge clk);
        chk("iq_empty", 64'(iq.size()), 64'd0);
        chk("dq_empty", 64'(dq.size()), 64'd0);
        chk("drop_total", 64'(seen_drop), 64'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
